// File: rtl/test_end_monitor.sv
// -----------------------------------------------------------------------------
// test_end_monitor
//
// End-of-test arbiter for simulation harnesses. It watches N_CHAN independent
// channels, each with a success, failure and heartbeat (progress) input. The
// monitor also enforces a global cycle limit and a no-progress stall limit.
// Once every enabled channel has succeeded, it waits in a drain window and
// then raises a single registered PASS/FAIL verdict. The verdict carries a
// reason code and the index of the failing channel.
//
// Parameters
//   N_CHAN        number of monitored channels (>= 1)
//   CNT_W         width of cycle_count and max_cycles
//   STALL_W       width of the stall counter and stall_limit
//   DRAIN_CYCLES  cycles spent in DRAIN after success (0 = straight to PASS)
//
// Ports
//   clock          single clock, all logic on posedge
//   reset          synchronous, active-high
//   max_cycles     global cycle limit, 0 = unlimited
//   stall_limit    max cycles without a heartbeat, 0 = disabled
//   chan_enable    channel participates in the verdict (sampled every cycle)
//   chan_success   per-channel success, sticky internally
//   chan_failure   per-channel failure, a single-cycle pulse is enough
//   chan_progress  per-channel heartbeat
//   cycle_count    cycles spent in RUN+DRAIN, frozen once a verdict is taken
//   state          0=RUN 1=DRAIN 2=PASS 3=FAIL
//   done           verdict valid, held until reset
//   passed/failed  verdict flags
//   reason         0=none 1=channel failure 2=timeout 3=stall
//   fail_chan      lowest failing enabled channel (valid when reason==1)
// -----------------------------------------------------------------------------
module test_end_monitor #(
  parameter int N_CHAN       = 4,
  parameter int CNT_W        = 64,
  parameter int STALL_W      = 32,
  parameter int DRAIN_CYCLES = 16,
  localparam int FC_W        = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CNT_W-1:0]   max_cycles,
  input  logic [STALL_W-1:0] stall_limit,
  input  logic [N_CHAN-1:0]  chan_enable,
  input  logic [N_CHAN-1:0]  chan_success,
  input  logic [N_CHAN-1:0]  chan_failure,
  input  logic [N_CHAN-1:0]  chan_progress,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [1:0]         state,
  output logic               done,
  output logic               passed,
  output logic               failed,
  output logic [1:0]         reason,
  output logic [FC_W-1:0]    fail_chan
);

  localparam int DR_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [1:0] RSN_NONE    = 2'd0;
  localparam logic [1:0] RSN_CHAN    = 2'd1;
  localparam logic [1:0] RSN_TIMEOUT = 2'd2;
  localparam logic [1:0] RSN_STALL   = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  state_t             st;
  logic [STALL_W-1:0] stall_cnt;
  logic [DR_W-1:0]    drain_cnt;
  logic [N_CHAN-1:0]  done_mask;

  // Saturating increments: the counters must never wrap back to a small value.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [STALL_W-1:0] sat_inc_stall(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [FC_W-1:0] lowest_idx(input logic [N_CHAN-1:0] v);
    logic [FC_W-1:0] idx;
    idx = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (v[i]) idx = FC_W'(i);
    end
    return idx;
  endfunction

  logic [N_CHAN-1:0] fail_en;
  logic [N_CHAN-1:0] succ_en;
  logic              any_fail;
  logic              all_ok;
  logic              prog_hit;
  logic              timeout;
  logic              stalled;
  logic [DR_W-1:0]   drain_nxt;
  logic              drain_last;

  assign fail_en  = chan_failure & chan_enable;
  assign succ_en  = chan_success & chan_enable;
  assign any_fail = |fail_en;
  // A success seen this very cycle counts, even though done_mask only
  // records it on the next edge.
  assign all_ok   = (chan_enable != '0) &&
                    (((done_mask | succ_en) & chan_enable) == chan_enable);
  // A heartbeat only counts from channels that still have work to do.
  assign prog_hit = |(chan_progress & chan_enable & ~done_mask);
  assign timeout  = (max_cycles != '0) && (cycle_count >= max_cycles);
  assign stalled  = (stall_limit != '0) && (stall_cnt >= stall_limit);

  assign drain_nxt  = drain_cnt + DR_W'(1);
  assign drain_last = (drain_nxt == DR_W'(DRAIN_CYCLES));

  assign state = st;

  // The cycle that decides a verdict is not added to cycle_count. The count
  // therefore equals the limit that tripped a timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= ST_RUN;
      cycle_count <= '0;
      stall_cnt   <= '0;
      drain_cnt   <= '0;
      done_mask   <= '0;
      done        <= 1'b0;
      passed      <= 1'b0;
      failed      <= 1'b0;
      reason      <= RSN_NONE;
      fail_chan   <= '0;
    end else begin
      unique case (st)
        ST_RUN: begin
          done_mask <= done_mask | succ_en;
          stall_cnt <= prog_hit ? '0 : sat_inc_stall(stall_cnt);
          if (any_fail) begin
            st        <= ST_FAIL;
            done      <= 1'b1;
            failed    <= 1'b1;
            reason    <= RSN_CHAN;
            fail_chan <= lowest_idx(fail_en);
          end else if (timeout) begin
            st     <= ST_FAIL;
            done   <= 1'b1;
            failed <= 1'b1;
            reason <= RSN_TIMEOUT;
          end else if (stalled) begin
            st     <= ST_FAIL;
            done   <= 1'b1;
            failed <= 1'b1;
            reason <= RSN_STALL;
          end else if (all_ok && (DRAIN_CYCLES == 0)) begin
            st     <= ST_PASS;
            done   <= 1'b1;
            passed <= 1'b1;
          end else begin
            if (all_ok) st <= ST_DRAIN;
            cycle_count <= sat_inc_cnt(cycle_count);
          end
        end

        // Timeout, stall and enable changes are deliberately ignored here;
        // only an enabled channel failure can still spoil the run.
        ST_DRAIN: begin
          done_mask <= done_mask | succ_en;
          if (prog_hit) stall_cnt <= '0;
          if (any_fail) begin
            st        <= ST_FAIL;
            done      <= 1'b1;
            failed    <= 1'b1;
            reason    <= RSN_CHAN;
            fail_chan <= lowest_idx(fail_en);
          end else if (drain_last) begin
            st        <= ST_PASS;
            done      <= 1'b1;
            passed    <= 1'b1;
            drain_cnt <= drain_nxt;
          end else begin
            drain_cnt   <= drain_nxt;
            cycle_count <= sat_inc_cnt(cycle_count);
          end
        end

        // PASS and FAIL are terminal: every register holds until reset.
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_end_monitor.sv
module tb_test_end_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        rst2  = 1'b1;
  logic [63:0] max_cycles = '0;
  logic [31:0] stall_limit = '0;
  logic [3:0]  chan_enable = '0, chan_success = '0, chan_failure = '0, chan_progress = '0;

  logic [63:0] cc0, cc1;
  logic [3:0]  cc2;
  logic [1:0]  st0, st1, st2, rsn0, rsn1, rsn2, fch0, fch1, fch2;
  logic        done0, done1, done2, pass0, pass1, pass2, fail0, fail1, fail2;

  test_end_monitor #(.N_CHAN(4), .CNT_W(64), .STALL_W(32), .DRAIN_CYCLES(16)) u0 (
    .clock(clk), .reset(reset), .max_cycles(max_cycles), .stall_limit(stall_limit),
    .chan_enable(chan_enable), .chan_success(chan_success), .chan_failure(chan_failure),
    .chan_progress(chan_progress), .cycle_count(cc0), .state(st0), .done(done0),
    .passed(pass0), .failed(fail0), .reason(rsn0), .fail_chan(fch0));

  test_end_monitor #(.N_CHAN(4), .CNT_W(64), .STALL_W(32), .DRAIN_CYCLES(0)) u1 (
    .clock(clk), .reset(reset), .max_cycles(max_cycles), .stall_limit(stall_limit),
    .chan_enable(chan_enable), .chan_success(chan_success), .chan_failure(chan_failure),
    .chan_progress(chan_progress), .cycle_count(cc1), .state(st1), .done(done1),
    .passed(pass1), .failed(fail1), .reason(rsn1), .fail_chan(fch1));

  test_end_monitor #(.N_CHAN(4), .CNT_W(4), .STALL_W(32), .DRAIN_CYCLES(16)) u2 (
    .clock(clk), .reset(rst2), .max_cycles(4'd0), .stall_limit(32'd0),
    .chan_enable(4'd0), .chan_success(4'd0), .chan_failure(4'd0),
    .chan_progress(4'd0), .cycle_count(cc2), .state(st2), .done(done2),
    .passed(pass2), .failed(fail2), .reason(rsn2), .fail_chan(fch2));

  int compared = 0;
  int mismatched = 0;

  logic [3:0] en_a[200];
  logic [3:0] su_a[200];
  logic [3:0] fa_a[200];
  logic [3:0] pr_a[200];

  // Cycle (in "state during cycle k" terms) at which each observation first appeared.
  int vc0, vc1, dc0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] lowest4(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic clear_trace();
    for (int i = 0; i < 200; i++) begin
      en_a[i] = 4'h0; su_a[i] = 4'h0; fa_a[i] = 4'h0; pr_a[i] = 4'h0;
    end
  endtask

  // Reference: walk the trace cycle by cycle and apply the verdict rules in
  // priority order. At RUN cycle t the cycle counter reads t. The stall
  // counter reads the number of cycles since the last useful heartbeat.
  task automatic model(input int L, input logic [63:0] mc, input logic [31:0] sl, input int dr,
                       output logic [1:0] st, output logic [1:0] rs, output logic [1:0] fc,
                       output longint cnt, output int vc, output int dc);
    logic [3:0] mask, f, se;
    int last_clear, drain_end;
    bit in_drain;
    st = 2'd0; rs = 2'd0; fc = 2'd0; vc = 0; dc = 0; cnt = 0;
    mask = 4'h0; last_clear = -1; drain_end = 0; in_drain = 0;
    for (int t = 0; t < L; t++) begin
      f  = fa_a[t] & en_a[t];
      se = su_a[t] & en_a[t];
      if (f != 4'h0) begin
        st = 2'd3; rs = 2'd1; fc = lowest4(f); vc = t + 1; cnt = t; return;
      end
      if (!in_drain) begin
        if (mc != 0 && 64'(t) >= mc) begin
          st = 2'd3; rs = 2'd2; vc = t + 1; cnt = t; return;
        end
        if (sl != 0 && longint'(t - last_clear - 1) >= longint'(sl)) begin
          st = 2'd3; rs = 2'd3; vc = t + 1; cnt = t; return;
        end
        if (en_a[t] != 4'h0 && ((mask | se) & en_a[t]) == en_a[t]) begin
          if (dr == 0) begin
            st = 2'd2; vc = t + 1; cnt = t; return;
          end
          in_drain = 1; drain_end = t + dr; dc = t + 1;
        end
        if ((pr_a[t] & en_a[t] & ~mask) != 4'h0) last_clear = t;
      end else if (t == drain_end) begin
        st = 2'd2; vc = t + 1; cnt = t; return;
      end
      mask = mask | se;
    end
    cnt = L;
    st  = in_drain ? 2'd1 : 2'd0;
  endtask

  task automatic run_trace(input string tag, input int L, input logic [63:0] mc, input logic [31:0] sl);
    logic [1:0] es, er, ef;
    longint ec;
    int ev, ed;
    max_cycles  = mc;
    stall_limit = sl;
    @(negedge clk);
    reset = 1'b1;
    chan_enable = 4'h0; chan_success = 4'h0; chan_failure = 4'h0; chan_progress = 4'h0;
    @(posedge clk); #1;
    check({tag, "_rst_state"}, 64'(st0), 64'd0);
    check({tag, "_rst_count"}, cc0, 64'd0);
    check({tag, "_rst_done"}, 64'(done0), 64'd0);
    check({tag, "_rst_reason"}, 64'(rsn0), 64'd0);
    vc0 = 0; vc1 = 0; dc0 = 0;
    for (int t = 0; t < L; t++) begin
      @(negedge clk);
      reset = 1'b0;
      chan_enable = en_a[t]; chan_success = su_a[t];
      chan_failure = fa_a[t]; chan_progress = pr_a[t];
      @(posedge clk); #1;
      if (vc0 == 0 && done0) vc0 = t + 1;
      if (dc0 == 0 && st0 == 2'd1) dc0 = t + 1;
      if (vc1 == 0 && done1) vc1 = t + 1;
    end
    model(L, mc, sl, 16, es, er, ef, ec, ev, ed);
    check({tag, "_state"}, 64'(st0), 64'(es));
    check({tag, "_reason"}, 64'(rsn0), 64'(er));
    check({tag, "_fail_chan"}, 64'(fch0), 64'(ef));
    check({tag, "_count"}, cc0, 64'(ec));
    check({tag, "_done"}, 64'(done0), 64'(es >= 2'd2));
    check({tag, "_passed"}, 64'(pass0), 64'(es == 2'd2));
    check({tag, "_failed"}, 64'(fail0), 64'(es == 2'd3));
    check({tag, "_verdict_cyc"}, 64'(vc0), 64'(ev));
    check({tag, "_drain_cyc"}, 64'(dc0), 64'(ed));
    model(L, mc, sl, 0, es, er, ef, ec, ev, ed);
    check({tag, "_d0_state"}, 64'(st1), 64'(es));
    check({tag, "_d0_reason"}, 64'(rsn1), 64'(er));
    check({tag, "_d0_fail_chan"}, 64'(fch1), 64'(ef));
    check({tag, "_d0_count"}, cc1, 64'(ec));
    check({tag, "_d0_verdict_cyc"}, 64'(vc1), 64'(ev));
  endtask

  task automatic load_t1();
    clear_trace();
    for (int i = 0; i < 200; i++) en_a[i] = 4'hF;
    su_a[5] = 4'b0001; su_a[9] = 4'b0010; su_a[12] = 4'b0100; su_a[20] = 4'b1000;
  endtask

  initial begin
    @(posedge clk); #1;
    check("sat_rst_count", 64'(cc2), 64'd0);
    rst2 = 1'b0;

    // 1: staggered success -> DRAIN at 21, PASS at 37.
    load_t1();
    run_trace("t1", 45, 64'd0, 32'd0);
    check("t1_drain_at_21", 64'(dc0), 64'd21);
    check("t1_pass_at_37", 64'(vc0), 64'd37);
    check("t1_d0_pass_at_21", 64'(vc1), 64'd21);

    // 2: timeout at 10, verdict held for 50 more cycles.
    clear_trace();
    for (int i = 0; i < 200; i++) en_a[i] = 4'hF;
    run_trace("t2", 62, 64'd10, 32'd0);
    check("t2_reason_timeout", 64'(rsn0), 64'd2);
    check("t2_count_10", cc0, 64'd10);

    // 3: heartbeat on chan 2 stops after cycle 29 -> stall FAIL at 39.
    clear_trace();
    for (int i = 0; i < 200; i++) en_a[i] = 4'hF;
    for (int i = 0; i < 30; i++) pr_a[i] = 4'b0100;
    run_trace("t3", 50, 64'd0, 32'd8);
    check("t3_stall_at_39", 64'(vc0), 64'd39);
    run_trace("t3_nolimit", 50, 64'd0, 32'd0);
    check("t3_no_verdict", 64'(done0), 64'd0);

    // 4: failure beats same-cycle success; disabled channel failure ignored.
    clear_trace();
    for (int i = 0; i < 200; i++) en_a[i] = 4'hF;
    su_a[3] = 4'hF; fa_a[3] = 4'b1010;
    run_trace("t4a", 20, 64'd0, 32'd0);
    check("t4a_fail_chan_1", 64'(fch0), 64'd1);
    clear_trace();
    for (int i = 0; i < 200; i++) en_a[i] = 4'b1110;
    fa_a[2] = 4'b0001; su_a[6] = 4'b1110;
    run_trace("t4b", 30, 64'd0, 32'd0);
    check("t4b_pass", 64'(pass0), 64'd1);

    // 5: failure on chan 3 at drain_cnt=5; DRAIN_CYCLES=0 build passes at 5.
    clear_trace();
    for (int i = 0; i < 200; i++) en_a[i] = 4'hF;
    su_a[4] = 4'hF; fa_a[10] = 4'b1000;
    run_trace("t5", 25, 64'd0, 32'd0);
    check("t5_fail_chan_3", 64'(fch0), 64'd3);
    check("t5_d0_pass", 64'(pass1), 64'd1);
    check("t5_d0_pass_at_5", 64'(vc1), 64'd5);

    // 6: reset inside DRAIN, done_mask must be forgotten, then re-run to PASS.
    load_t1();
    run_trace("t6_pre", 25, 64'd0, 32'd0);
    check("t6_in_drain", 64'(st0), 64'd1);
    clear_trace();
    for (int i = 0; i < 200; i++) en_a[i] = 4'hF;
    su_a[2] = 4'b0111;
    run_trace("t6_mask", 35, 64'd30, 32'd0);
    check("t6_mask_timeout", 64'(rsn0), 64'd2);
    load_t1();
    run_trace("t6_rerun", 45, 64'd0, 32'd0);
    check("t6_rerun_pass", 64'(pass0), 64'd1);

    // Randomized traces against the reference.
    for (int n = 0; n < 30; n++) begin
      int L, chg;
      logic [3:0] e;
      logic [63:0] mc;
      logic [31:0] sl;
      clear_trace();
      L   = int'($urandom_range(100, 150));
      e   = 4'($urandom_range(0, 15));
      chg = int'($urandom_range(0, 199));
      for (int t = 0; t < L; t++) begin
        if (t == chg) e = 4'($urandom_range(0, 15));
        en_a[t] = e;
        for (int c = 0; c < 4; c++) begin
          su_a[t][c] = ($urandom_range(0, 14) == 0);
          fa_a[t][c] = ($urandom_range(0, 249) == 0);
          pr_a[t][c] = ($urandom_range(0, 3) == 0);
        end
      end
      mc = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(20, 120));
      sl = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(2, 10));
      run_trace($sformatf("rnd%0d", n), L, mc, sl);
    end

    // Narrow-counter build has run thousands of cycles with no way to end.
    check("sat_count_15", 64'(cc2), 64'd15);
    check("sat_state_run", 64'(st2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
